quad_input_conditioner: RTL and testbench
=========================================

Name: quad_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the motor-encoder speed/direction block.
- Takes raw quadrature lines A/B from the motor connector and synchronises them into clk.
- Removes glitches shorter than FILT_LEN cycles and decodes the clean pair into single-cycle step pulses with direction, plus a wrapping position count.
- Its clean outA/outB drive the downstream tick counters, so noise spikes never reach edge-clocked logic. Illegal transitions are flagged and counted for diagnostics.

Parameters:
FILT_LEN, 4, consecutive clk cycles a synchronised level must hold before the filtered output takes it (legal 2..255).
CNT_W, 16, width of err_count and position.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
inA_raw  input  1  raw encoder channel A, asynchronous
inB_raw  input  1  raw encoder channel B, asynchronous
clear_err  input  1  synchronous clear of err_count, level-sensitive
outA  output  1  filtered channel A
outB  output  1  filtered channel B
step  output  1  one-cycle pulse per legal quadrature transition
step_dir  output  1  direction of the current step: 1 = forward, 0 = reverse; holds its value between steps
err_pulse  output  1  one-cycle pulse on an illegal transition (A and B change together)
err_count  output  CNT_W  saturating count of illegal transitions
position  output  CNT_W  signed position: +1 per forward step, -1 per reverse step, wraps modulo 2^CNT_W

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low. While reset=0 at a clk edge:
  - all registers clear;
  - outA = outB = 0, step = 0, step_dir = 0, err_pulse = 0, err_count = 0, position = 0;
  - startup counter is loaded.
  - Reset asserted mid-operation aborts any pending filter count; no step or err_pulse is produced in that cycle.
- Synchroniser: two flip-flops per channel (sA, sB). No other logic uses the raw inputs.
- Filter, per channel, with counter fc of width ceil(log2(FILT_LEN)):
  - s == out: fc <= 0.
  - s != out and fc == FILT_LEN-1: out <= s, fc <= 0.
  - Otherwise: fc <= fc + 1.
  - A raw level stable from edge k appears on out at edge k+2+FILT_LEN.
  - A pulse lasting fewer than FILT_LEN synchronised cycles is discarded, and the count restarts.
- Decoder: registers prev = {outA,outB} every cycle and compares it with the current {outA,outB}. Gray cycle (A,B):
  - Forward: 00→01→11→10→00.
  - Reverse: the opposite order.
- Decoder outputs, registered with 1 cycle after the filtered change:
  - Legal forward change: step = 1, step_dir = 1, position += 1.
  - Legal reverse change: step = 1, step_dir = 0, position -= 1.
  - Both bits changed: err_pulse = 1; step stays 0; position and step_dir unchanged; err_count += 1 unless already all-ones (saturates).
  - No change: step = 0, err_pulse = 0.
- Startup blanking: for the first FILT_LEN+3 cycles after reset release, prev tracks the filtered pair but step, err_pulse, position and err_count are frozen. This prevents a false error when both lines idle high at power-up.
- clear_err = 1: err_count <= 0 on that edge. If an error occurs in the same cycle, clear wins (count = 0) but err_pulse still fires.
- Position wrap: 0xFFFF + 1 → 0x0000; 0x0000 - 1 → 0xFFFF (CNT_W = 16). No flag is raised.
- Total raw-to-step latency is 3+FILT_LEN cycles.

Test Plan:
- Reset, then hold inA_raw=inB_raw=1: outA/outB rise together 6 cycles after the sample (FILT_LEN=4). No err_pulse, thanks to blanking. err_count=0.
- After blanking, drive the forward sequence 00,01,11,10,00 with each state held 20 cycles: 4 step pulses, step_dir=1, position=4, err_count=0. Each pulse comes 7 cycles after its raw edge.
- Then drive the reverse sequence for 6 transitions: 6 step pulses, step_dir=0, position=0xFFFE.
- Glitch: from A=0, pulse inA_raw high for 3 cycles, then for 4 cycles. The 3-cycle glitch gives no outA change and no step. The 4-cycle pulse produces outA high for 4 cycles and two steps (+1 then -1).
- Illegal: from 00, switch both raw lines to 11 in the same cycle: one err_pulse, err_count=1, no step, position unchanged. Assert clear_err in the same cycle as a second illegal jump: err_pulse=1, err_count=0.
- Mid-operation reset: assert reset=0 for 1 cycle during a pending filter count: all outputs 0 next cycle, and no step is issued for the aborted edge.

Source files
------------

// File: rtl/quad_input_conditioner_if.sv
// quad_input_conditioner_if: groups the encoder-side lines and the decoded
// results of quad_input_conditioner into one bundle.
//   master : drives inA_raw/inB_raw/clear_err, observes the results
//   slave  : the conditioner itself
// Signals:
//   inA_raw, inB_raw  raw asynchronous quadrature channels
//   clear_err         level-sensitive synchronous clear of err_count
//   outA, outB        filtered channels
//   step, step_dir    one-cycle step pulse and its direction (1 = forward)
//   err_pulse         one-cycle pulse on an illegal (double) transition
//   err_count         saturating illegal-transition count
//   position          wrapping signed position
interface quad_input_conditioner_if #(
  parameter int CNT_W = 16
);
  logic             inA_raw;
  logic             inB_raw;
  logic             clear_err;
  logic             outA;
  logic             outB;
  logic             step;
  logic             step_dir;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] position;

  modport master (
    output inA_raw, inB_raw, clear_err,
    input  outA, outB, step, step_dir, err_pulse, err_count, position
  );

  modport slave (
    input  inA_raw, inB_raw, clear_err,
    output outA, outB, step, step_dir, err_pulse, err_count, position
  );
endinterface

// File: rtl/quad_input_conditioner.sv
// quad_input_conditioner: synchronises raw quadrature lines A/B, rejects
// glitches shorter than FILT_LEN cycles and decodes the clean pair into step
// pulses, direction, a wrapping position and a saturating error count.
// Ports:
//   clk    system clock
//   reset  synchronous, active-low
//   bus    quad_input_conditioner_if.slave (raw inputs, clear_err, results)
// Raw-to-step latency is FILT_LEN+3 cycles.

// Per-channel front end: 2-flop synchroniser followed by a persistence filter.
module qic_chan #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILT_LEN - 1);

  logic            s1, s2;
  logic [FC_W-1:0] fc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      fc   <= '0;
      filt <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any return to the current output level restarts the count, so only
      // FILT_LEN consecutive disagreeing samples move the output.
      if (s2 == filt) begin
        fc <= '0;
      end else if (fc == FC_MAX) begin
        filt <= s2;
        fc   <= '0;
      end else begin
        fc <= fc + 1'b1;
      end
    end
  end
endmodule

module quad_input_conditioner #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 16
) (
  input logic                     clk,
  input logic                     reset,
  quad_input_conditioner_if.slave bus
);
  localparam int NUM_CH = 2;
  localparam int BLANK  = FILT_LEN + 3;
  localparam int BW     = $clog2(BLANK + 1);

  logic [NUM_CH-1:0] raw, filt, prev;   // bit 1 = A, bit 0 = B
  logic [BW-1:0]     blank_cnt;
  logic              active;
  logic              fwd, rev, ill;
  logic              step_r, dir_r, err_r;
  logic [CNT_W-1:0]  ecnt, pos;

  assign raw = {bus.inA_raw, bus.inB_raw};

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      qic_chan #(.FILT_LEN(FILT_LEN)) u_chan (
        .clk  (clk),
        .reset(reset),
        .raw  (raw[i]),
        .filt (filt[i])
      );
    end
  endgenerate

  // Blanking covers the time the filters need to settle after reset, so an
  // input pair idling at 11 does not read as a 00->11 illegal jump.
  assign active = (blank_cnt == '0);

  // Gray cycle (A,B) forward: 00 -> 01 -> 11 -> 10 -> 00.
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    ill = 1'b0;
    case ({prev, filt})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: ill = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev      <= '0;
      blank_cnt <= BW'(BLANK);
      step_r    <= 1'b0;
      dir_r     <= 1'b0;
      err_r     <= 1'b0;
      ecnt      <= '0;
      pos       <= '0;
    end else begin
      prev <= filt;
      if (!active) blank_cnt <= blank_cnt - 1'b1;
      step_r <= active & (fwd | rev);
      err_r  <= active & ill;
      if (active && fwd) begin
        dir_r <= 1'b1;
        pos   <= pos + 1'b1;
      end else if (active && rev) begin
        dir_r <= 1'b0;
        pos   <= pos - 1'b1;
      end
      // Clear beats a coincident error; the pulse itself still fires.
      if (bus.clear_err)                    ecnt <= '0;
      else if (active && ill && ecnt != '1) ecnt <= ecnt + 1'b1;
    end
  end

  assign bus.outA      = filt[1];
  assign bus.outB      = filt[0];
  assign bus.step      = step_r;
  assign bus.step_dir  = dir_r;
  assign bus.err_pulse = err_r;
  assign bus.err_count = ecnt;
  assign bus.position  = pos;
endmodule

// File: tb/tb_quad_input_conditioner.sv
// Directed bench for quad_input_conditioner (FILT_LEN=4, CNT_W=16).
// A behavioural model built on raw-sample history and Gray-index arithmetic
// is compared with the DUT every cycle; literal checks pin key results.
module tb_quad_input_conditioner;
  localparam int F = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quad_input_conditioner_if #(.CNT_W(W)) bus ();

  quad_input_conditioner #(.FILT_LEN(F), .CNT_W(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- behavioural model ----------------
  // hA/hB hold raw samples, [0] newest. The filtered level flips once the
  // last F synchronised samples (two samples behind raw) all disagree with it.
  logic [F:0] hA = '0, hB = '0;
  logic       mA = 1'b0, mB = 1'b0, mstep = 1'b0, mdir = 1'b0, merr = 1'b0;
  logic [1:0] mprev = 2'b00;
  int         mpos = 0, mec = 0, since = 0;

  function automatic int gidx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // 1 = forward, 3 = reverse, 2 = illegal, 0 = no change
  function automatic int delta(input logic [1:0] p, input logic [1:0] c);
    return (gidx(c) - gidx(p)) & 3;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      hA <= '0; hB <= '0; mA <= 1'b0; mB <= 1'b0; mprev <= 2'b00;
      mstep <= 1'b0; mdir <= 1'b0; merr <= 1'b0; mpos <= 0; mec <= 0; since <= 0;
    end else begin
      hA <= {hA[F-1:0], bus.inA_raw};
      hB <= {hB[F-1:0], bus.inB_raw};
      if (hA[F:1] == {F{~mA}}) mA <= ~mA;
      if (hB[F:1] == {F{~mB}}) mB <= ~mB;
      mprev <= {mA, mB};
      mstep <= 1'b0;
      merr  <= 1'b0;
      if (since >= F + 3) begin
        case (delta(mprev, {mA, mB}))
          1: begin mstep <= 1'b1; mdir <= 1'b1; mpos <= mpos + 1; end
          3: begin mstep <= 1'b1; mdir <= 1'b0; mpos <= mpos - 1; end
          2: begin merr <= 1'b1; if (mec < (1 << W) - 1) mec <= mec + 1; end
          default: ;
        endcase
      end
      if (bus.clear_err) mec <= 0;
      if (since < 1000) since <= since + 1;
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  int   nsteps = 0, nerrs = 0, nrisesA = 0, runA = 0, last_runA = 0;
  logic lastA = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle",
          {27'd0, bus.outA, bus.outB, bus.step, bus.step_dir, bus.err_pulse, bus.err_count, bus.position},
          {27'd0, mA, mB, mstep, mdir, merr, mec[W-1:0], mpos[W-1:0]});
      if (bus.step)            nsteps++;
      if (bus.err_pulse)       nerrs++;
      if (bus.outA && !lastA)  nrisesA++;
      if (bus.outA) runA++;
      else begin
        if (runA > 0) last_runA = runA;
        runA = 0;
      end
      lastA = bus.outA;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input logic a, input logic b, input int n);
    bus.inA_raw = a;
    bus.inB_raw = b;
    cyc(n);
  endtask

  initial begin
    int d, lat, s0, e0, r0;
    reset = 1'b0;
    bus.inA_raw = 1'b0; bus.inB_raw = 1'b0; bus.clear_err = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    chk("rst_outs", {59'd0, bus.outA, bus.outB, bus.step, bus.step_dir, bus.err_pulse}, 64'd0);
    chk("rst_ecnt", {48'd0, bus.err_count}, 64'd0);
    chk("rst_pos",  {48'd0, bus.position}, 64'd0);

    // Power-up with both lines idling high: rise after 6 cycles, blanked.
    reset = 1'b1; bus.inA_raw = 1'b1; bus.inB_raw = 1'b1;
    d = cyc_n; lat = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.outA && bus.outB && lat < 0) lat = cyc_n - d;
    end
    chk("pwrup_lat",  64'(lat), 64'd6);
    chk("pwrup_errs", 64'(nerrs), 64'd0);
    chk("pwrup_ecnt", {48'd0, bus.err_count}, 64'd0);
    chk("model_pwrup", {62'd0, mA, mB}, 64'd3);

    // Restart from 00 and run the forward cycle.
    reset = 1'b0; bus.inA_raw = 1'b0; bus.inB_raw = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(15);
    s0 = nsteps;
    bus.inB_raw = 1'b1;
    d = cyc_n; lat = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (bus.step && lat < 0) lat = cyc_n - d;
    end
    chk("fwd_lat", 64'(lat), 64'd7);
    drv(1, 1, 20); drv(1, 0, 20); drv(0, 0, 20);
    chk("fwd_steps", 64'(nsteps - s0), 64'd4);
    chk("fwd_dir",   {63'd0, bus.step_dir}, 64'd1);
    chk("fwd_pos",   {48'd0, bus.position}, 64'd4);
    chk("fwd_ecnt",  {48'd0, bus.err_count}, 64'd0);
    chk("model_fwd_pos", 64'(mpos), 64'd4);

    // Reverse, six transitions: 4 - 6 wraps to 0xFFFE.
    s0 = nsteps;
    drv(1, 0, 20); drv(1, 1, 20); drv(0, 1, 20);
    drv(0, 0, 20); drv(1, 0, 20); drv(1, 1, 20);
    chk("rev_steps", 64'(nsteps - s0), 64'd6);
    chk("rev_dir",   {63'd0, bus.step_dir}, 64'd0);
    chk("rev_pos",   {48'd0, bus.position}, 64'hFFFE);
    chk("model_rev_pos", {48'd0, mpos[15:0]}, 64'hFFFE);

    // Glitches from (A,B)=01; position 0xFFFD here.
    drv(0, 1, 20);
    s0 = nsteps; r0 = nrisesA;
    drv(1, 1, 3); drv(0, 1, 25);
    chk("glitch3_steps", 64'(nsteps - s0), 64'd0);
    chk("glitch3_outA",  64'(nrisesA - r0), 64'd0);
    drv(1, 1, 4); drv(0, 1, 25);
    chk("pulse4_steps", 64'(nsteps - s0), 64'd2);
    chk("pulse4_rises", 64'(nrisesA - r0), 64'd1);
    chk("pulse4_width", 64'(last_runA), 64'd4);
    chk("pulse4_pos",   {48'd0, bus.position}, 64'hFFFD);

    // Illegal jumps from 00 (position 0xFFFC).
    drv(0, 0, 20);
    s0 = nsteps; e0 = nerrs;
    drv(1, 1, 20);
    chk("ill_errs",  64'(nerrs - e0), 64'd1);
    chk("ill_ecnt",  {48'd0, bus.err_count}, 64'd1);
    chk("ill_steps", 64'(nsteps - s0), 64'd0);
    chk("ill_pos",   {48'd0, bus.position}, 64'hFFFC);
    // Second jump; clear_err lands on the decode edge (drive + 7).
    drv(0, 0, 6);
    bus.clear_err = 1'b1;
    cyc(1);
    bus.clear_err = 1'b0;
    cyc(15);
    chk("clr_errs", 64'(nerrs - e0), 64'd2);
    chk("clr_ecnt", {48'd0, bus.err_count}, 64'd0);

    // Reset while A's filter count is pending.
    s0 = nsteps;
    drv(1, 0, 3);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("midrst_outs",
        {27'd0, bus.outA, bus.outB, bus.step, bus.step_dir, bus.err_pulse, bus.err_count, bus.position},
        64'd0);
    cyc(25);
    chk("midrst_steps", 64'(nsteps - s0), 64'd0);
    chk("midrst_pos",   {48'd0, bus.position}, 64'd0);
    chk("midrst_outA",  {63'd0, bus.outA}, 64'd1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
